// File: rtl/mult_div_hilo.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Signed operations run on magnitudes and get their signs restored in FIX.
module mult_div_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_data
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t               state_q;
    logic [CW-1:0]        count_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]     opnd_q;
    logic                 isDiv_q;
    logic                 negRes_q;
    logic                 negRem_q;
    logic                 divZero_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 done_q;

    logic                 isSigned;
    logic [WIDTH-1:0]     absRs;
    logic [WIDTH-1:0]     absRt;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       partial;
    logic [WIDTH:0]       diff;
    logic [2*WIDTH-1:0]   prodFix;
    logic [WIDTH-1:0]     quoFix;
    logic [WIDTH-1:0]     remFix;

    assign isSigned = ~func[0];
    assign absRs    = (isSigned && rs_data[WIDTH-1]) ? -rs_data : rs_data;
    assign absRt    = (isSigned && rt_data[WIDTH-1]) ? -rt_data : rt_data;

    // acc_q holds {partial product, multiplier} for multiply and
    // {remainder, dividend/quotient} for divide; both shift one bit per cycle.
    always_comb begin
        sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        partial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff    = partial - {1'b0, opnd_q};
        acc_d   = {sum, acc_q[WIDTH-1:1]};
        if (isDiv_q) begin
            if (!diff[WIDTH])
                acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
                acc_d = {partial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    // With a zero divisor the remainder path still reproduces |rs|, so only
    // the quotient needs forcing to all ones.
    always_comb begin
        prodFix = negRes_q ? -acc_q : acc_q;
        quoFix  = divZero_q ? '1 : (negRes_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
        remFix  = negRem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            isDiv_q   <= 1'b0;
            negRes_q  <= 1'b0;
            negRem_q  <= 1'b0;
            divZero_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state_q == FIX);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        case (func)
                            F_MULT, F_MULTU: begin
                                acc_q     <= {{WIDTH{1'b0}}, absRt};
                                opnd_q    <= absRs;
                                isDiv_q   <= 1'b0;
                                negRes_q  <= isSigned & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                                negRem_q  <= 1'b0;
                                divZero_q <= 1'b0;
                                count_q   <= '0;
                                state_q   <= RUN;
                            end
                            F_DIV, F_DIVU: begin
                                acc_q     <= {{WIDTH{1'b0}}, absRs};
                                opnd_q    <= absRt;
                                isDiv_q   <= 1'b1;
                                negRes_q  <= isSigned & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                                negRem_q  <= isSigned & rs_data[WIDTH-1];
                                divZero_q <= (rt_data == '0);
                                count_q   <= '0;
                                state_q   <= RUN;
                            end
                            F_MTHI:  hi_q <= rs_data;
                            F_MTLO:  lo_q <= rs_data;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == CW'(WIDTH - 1))
                        state_q <= FIX;
                end
                FIX: begin
                    if (isDiv_q) begin
                        hi_q <= remFix;
                        lo_q <= quoFix;
                    end else begin
                        hi_q <= prodFix[2*WIDTH-1:WIDTH];
                        lo_q <= prodFix[WIDTH-1:0];
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign mf_data = (func == F_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_hilo.sv
// Directed plus randomized checks of mult_div_hilo against an arithmetic
// reference model (64-bit integer multiply/divide).
module tb_mult_div_hilo;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  func = 6'b0;
    logic [31:0] rs_data = 32'b0;
    logic [31:0] rt_data = 32'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf_data;

    int checks = 0;
    int errors = 0;

    mult_div_hilo #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .func(func),
        .rs_data(rs_data), .rt_data(rt_data), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .mf_data(mf_data)
    );

    always #5 clk = ~clk;

    // Reference result {hi, lo} straight from integer arithmetic.
    function automatic logic [63:0] refModel(logic [5:0] f, logic [31:0] a, logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = 64'b0;
        case (f)
            F_MULT:  res = sa * sb;
            F_MULTU: res = {32'b0, a} * {32'b0, b};
            F_DIV: begin
                if (b == 32'b0) res = {a, 32'hFFFFFFFF};
                else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            F_DIVU: begin
                if (b == 32'b0) res = {a, 32'hFFFFFFFF};
                else res = {a % b, a / b};
            end
            default: res = 64'b0;
        endcase
        return res;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
        @(negedge clk);
        start   = 1'b1;
        func    = f;
        rs_data = rs;
        rt_data = rt;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Count busy cycles; optionally pulse a MULT request partway through.
    task automatic waitDone(input int injectAt, output int busyCycles);
        busyCycles = 0;
        while (busy === 1'b1 && busyCycles < 100) begin
            busyCycles++;
            if (busyCycles == injectAt) begin
                start   = 1'b1;
                func    = F_MULT;
                rs_data = 32'h7;
                rt_data = 32'h9;
            end
            if (busyCycles == injectAt + 3) start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic runOp(input string tag, input logic [5:0] f, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] expHi,
                         input logic [31:0] expLo, input int injectAt);
        int cyc;
        applyStimulus(f, rs, rt);
        waitDone(injectAt, cyc);
        checkOutput({tag, " busyCycles"}, 64'(cyc), 64'd33);
        checkOutput({tag, " done"}, 64'(done), 64'd1);
        checkOutput({tag, " hi"}, 64'(hi), 64'(expHi));
        checkOutput({tag, " lo"}, 64'(lo), 64'(expLo));
        @(negedge clk);
        checkOutput({tag, " doneOnce"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [63:0] exp;
        logic [5:0]  f;
        logic [31:0] a, b;
        int doneCount, busySeen;

        // Reset held for two cycles.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset hi", 64'(hi), 64'd0);
        checkOutput("reset lo", 64'(lo), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        rst_n = 1'b1;

        // Reset during a MULT aborts it.
        applyStimulus(F_MULT, 32'h12345678, 32'h9ABCDEF0);
        checkOutput("abort busyBefore", 64'(busy), 64'd1);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("abort busy", 64'(busy), 64'd0);
        doneCount = 0;
        busySeen  = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) doneCount++;
            if (busy === 1'b1) busySeen++;
        end
        checkOutput("abort doneCount", 64'(doneCount), 64'd0);
        checkOutput("abort busySeen", 64'(busySeen), 64'd0);
        checkOutput("abort hi", 64'(hi), 64'd0);
        checkOutput("abort lo", 64'(lo), 64'd0);

        // Directed arithmetic cases.
        runOp("MULT -3*5", F_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
        func = F_MFLO;
        #1 checkOutput("MFLO", 64'(mf_data), 64'hFFFFFFF1);
        func = F_MFHI;
        #1 checkOutput("MFHI", 64'(mf_data), 64'hFFFFFFFF);
        runOp("MULTU max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
        runOp("DIV -7/2", F_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        runOp("DIVU 100/7", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0);
        runOp("DIVU by0", F_DIVU, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 0);
        runOp("DIV by0 neg", F_DIV, 32'hFFFFFF00, 32'd0, 32'hFFFFFF00, 32'hFFFFFFFF, 0);
        runOp("DIV ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);

        // MTHI / MTLO take effect at the next edge without going busy.
        applyStimulus(F_MTHI, 32'hAAAA5555, 32'h0);
        checkOutput("MTHI hi", 64'(hi), 64'hAAAA5555);
        checkOutput("MTHI busy", 64'(busy), 64'd0);
        applyStimulus(F_MTLO, 32'h0F0F1234, 32'h0);
        checkOutput("MTLO lo", 64'(lo), 64'h0F0F1234);
        checkOutput("MTLO hi", 64'(hi), 64'hAAAA5555);

        // MULT request while a DIV is running must be ignored.
        runOp("DIV overlap", F_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 5);
        doneCount = 0;
        busySeen  = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) doneCount++;
            if (busy === 1'b1) busySeen++;
        end
        checkOutput("overlap extraDone", 64'(doneCount), 64'd0);
        checkOutput("overlap busySeen", 64'(busySeen), 64'd0);
        checkOutput("overlap lo", 64'(lo), 64'hFFFFFFF2);

        // Randomized operations against the reference model.
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       f = F_MULT;
                1:       f = F_MULTU;
                2:       f = F_DIV;
                default: f = F_DIVU;
            endcase
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 :
                (($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 300)) : 32'($urandom));
            exp = refModel(f, a, b);
            runOp($sformatf("rand%0d f=%b a=%h b=%h", i, f, a, b), f, a, b, exp[63:32], exp[31:0], 0);
            if (i % 6 == 5) begin
                a = $urandom;
                applyStimulus(F_MTLO, a, 32'h0);
                checkOutput($sformatf("rand MTLO %0d", i), 64'(lo), 64'(a));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_hilo.md
Name: mult_div_hilo

Overview:
- Iterative multiply/divide unit with the architectural HI/LO registers.
- Sits beside the ALU in the execute path and handles the R-type funct codes the ALU control does not decode: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- Long operations take multiple cycles. The main control stalls PC/register write-back while busy is high.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count = WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  qualifies func/rs_data/rt_data for this cycle; from main control when opcode is R-type.
- func  input  6  instruction funct field.
- rs_data  input  WIDTH  rs operand (multiplicand/dividend; source for MTHI/MTLO).
- rt_data  input  WIDTH  rt operand (multiplier/divisor).
- busy  output  1  high while a MULT/DIV is in progress; control stalls on it.
- done  output  1  one-cycle pulse when HI/LO have just been updated by MULT/DIV.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- mf_data  output  WIDTH  combinational: hi when func==010000 (MFHI), else lo.

Behaviour:
- Everything is clocked on the rising edge of clk, synchronous reset only.
- Reset (rst_n=0 at an edge):
  - state=IDLE; hi=lo=0; busy=0; done=0; internal counters/accumulators cleared.
  - Reset mid-operation aborts the operation; no HI/LO update.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, WIDTH iterations.
  - FIX: busy=1, sign correction and HI/LO write.
- IDLE, start=1, func decode:
  - 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU: latch operands → RUN, count=0.
    - Signed ops latch absolute values and record result signs:
      - product sign = sign(rs) XOR sign(rt).
      - quotient sign = sign(rs) XOR sign(rt).
      - remainder sign = sign(rs).
  - 010001 MTHI: hi<=rs_data, stay IDLE.
  - 010011 MTLO: lo<=rs_data, stay IDLE.
  - 010000 MFHI / 010010 MFLO: no state change (read via mf_data).
  - Any other func: ignored.
- start while busy=1: ignored; func/operands not sampled.
- RUN: one iteration per cycle; count increments; after WIDTH iterations (count==WIDTH-1) → FIX.
  - Multiply: shift-add on a 2*WIDTH unsigned accumulator.
  - Divide: restoring divide, one quotient bit per cycle.
- FIX (one cycle): apply two's-complement negation per the recorded signs, then write.
  - Multiply: write {hi,lo} = 2*WIDTH product.
  - Divide: write lo=quotient, hi=remainder.
  - State → IDLE.
- done: registered, high exactly one cycle after the FIX edge; busy is 0 in that same cycle.
- Latency: start sampled at edge E0 → busy=1 after E0 through E(WIDTH+1) → hi/lo valid and done=1 after E(WIDTH+1). This is 33 cycles at WIDTH=32.
- mf_data reflects current hi/lo; it is not stalled by busy. Control must not issue MF* while busy.
- Divide by zero (rt=0), signed or unsigned: lo=all ones, hi=rs_data (original signed value); normal latency; no exception.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0; normal latency.
- Multiplication width: full 2*WIDTH product, never truncated.

Test Plan:
- Reset and idle: rst_n=0 for 2 cycles → hi=lo=0, busy=0, done=0. Assert rst_n=0 during RUN of a MULT → state IDLE, hi/lo stay 0, no done pulse.
- MULT rs=0xFFFFFFFD (-3), rt=5 →
  - busy high 33 cycles.
  - then done pulse with hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - mf_data=0xFFFFFFF1 with func=MFLO, 0xFFFFFFFF with func=MFHI.
- MULTU rs=rt=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001 after 33 cycles.
- DIV rs=0xFFFFFFF9 (-7), rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=100, rt=7 → lo=14, hi=2.
- DIVU rs=0x1234, rt=0 → lo=0xFFFFFFFF, hi=0x1234. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Control/handshake:
  - MTHI rs=0xAAAA5555 → hi updates next edge, busy stays 0.
  - start with MULT asserted during an active DIV → ignored; the DIV result is unchanged and exactly one done pulse occurs.
